// File: rtl/tvm_loop_nest_gen_pkg.sv
// tvm_loop_defs: shared state encoding, depth limit and level slice macro
// for the nested loop iterator generator.
`ifndef TVM_LOOP_DEFS_SV
`define TVM_LOOP_DEFS_SV
`define TVM_LVL(vec, k, w) vec[(k)*(w) +: (w)]

package tvm_loop_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_DEPTH = 8;

endpackage

`endif

// File: rtl/tvm_loop_level.sv
// tvm_loop_level: one loop level with latched begin/end/step; wraps to begin
// and carries out when cur+step (one extra bit) reaches end.
module tvm_loop_level #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] cfg_begin,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic [WIDTH-1:0] cfg_step,
    output logic [WIDTH-1:0] cur,
    output logic             last,
    output logic             carry_out,
    output logic             empty
);

    logic [WIDTH-1:0] r_beg;
    logic [WIDTH-1:0] r_end;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH:0]   w_next;

    // extra carry bit keeps a large step near 2^WIDTH from wrapping below end
    assign w_next    = {1'b0, r_cur} + {1'b0, r_step};
    assign last      = w_next >= {1'b0, r_end};
    assign carry_out = carry_in & last;
    assign empty     = r_beg >= r_end;
    assign cur       = r_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beg  <= '0;
            r_end  <= '0;
            r_step <= '0;
            r_cur  <= '0;
        end else if (load) begin
            r_beg  <= cfg_begin;
            r_end  <= cfg_end;
            r_step <= (cfg_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cfg_step;
            r_cur  <= cfg_begin;
        end else if (carry_in) begin
            r_cur  <= last ? r_beg : w_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tvm_loop_nest_gen.sv
// tvm_loop_nest_gen: DEPTH-level nested loop iterator with valid/ready.
// Optional linear beat counter flat_idx under TVM_LOOP_FLAT_INDEX_EN.
module tvm_loop_nest_gen
    import tvm_loop_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DEPTH*WIDTH-1:0] cfg_begin,
    input  logic [DEPTH*WIDTH-1:0] cfg_end,
    input  logic [DEPTH*WIDTH-1:0] cfg_step,
    output logic                   busy,
    output logic                   iter_valid,
    input  logic                   iter_ready,
    output logic [DEPTH*WIDTH-1:0] iter,
    output logic [DEPTH-1:0]       iter_last,
`ifdef TVM_LOOP_FLAT_INDEX_EN
    output logic [DEPTH*WIDTH-1:0] flat_idx,
`endif
    output logic                   done
);

    state_t                 r_state;
    state_t                 w_nxt;
    logic                   w_load;
    logic                   w_adv;
    logic                   w_empty;
    logic [DEPTH:0]         w_carry;
    logic [DEPTH-1:0]       w_last;
    logic [DEPTH-1:0]       w_empty_v;
    logic [DEPTH*WIDTH-1:0] w_cur;

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("DEPTH out of range");
    end

    assign w_empty    = |w_empty_v;
    assign w_load     = (r_state == ST_IDLE) && start && !abort;
    assign w_adv      = (r_state == ST_RUN) && !w_empty && iter_ready && !abort;
    assign w_carry[0] = w_adv;

    for (genvar g = 0; g < DEPTH; g++) begin : g_lvl
        tvm_loop_level #(.WIDTH(WIDTH)) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load),
            .carry_in  (w_carry[g]),
            .cfg_begin (`TVM_LVL(cfg_begin, g, WIDTH)),
            .cfg_end   (`TVM_LVL(cfg_end, g, WIDTH)),
            .cfg_step  (`TVM_LVL(cfg_step, g, WIDTH)),
            .cur       (`TVM_LVL(w_cur, g, WIDTH)),
            .last      (w_last[g]),
            .carry_out (w_carry[g+1]),
            .empty     (w_empty_v[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    // a zero-trip run spends one silent RUN cycle, so done lands two cycles after start
    always_comb begin
        w_nxt = ST_IDLE;
        unique case (r_state)
            ST_IDLE: w_nxt = w_load ? ST_RUN : ST_IDLE;
            ST_RUN:  w_nxt = abort ? ST_IDLE : (w_empty || w_carry[DEPTH]) ? ST_DONE : ST_RUN;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
        iter_valid = (r_state == ST_RUN) && !w_empty;
        done       = r_state == ST_DONE;
        iter       = iter_valid ? w_cur : '0;
        iter_last  = iter_valid ? w_last : '0;
    end

`ifdef TVM_LOOP_FLAT_INDEX_EN
    logic [DEPTH*WIDTH-1:0] r_flat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_flat <= '0;
        else if (w_load || abort)
            r_flat <= '0;
        else if (w_adv)
            r_flat <= r_flat + {{(DEPTH*WIDTH-1){1'b0}}, 1'b1};
    end

    assign flat_idx = r_flat;
`endif

endmodule
